// File: rtl/regfile_port_arbiter.sv
// Shares the regfile write port and read port B between processor and test host; p_stall rises 1 cycle after a drain/read trigger.
// Test writes are backpressured by t_wready (= !full); defining ARB_STATS_EN adds a saturating stall-cycle counter on stall_count.
module regfile_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p_we,
  input  logic [4:0]  p_wreg,
  input  logic [31:0] p_wdata,
  input  logic [4:0]  p_rregB,
  output logic        p_stall,
  input  logic        t_wvalid,
  output logic        t_wready,
  input  logic [4:0]  t_wreg,
  input  logic [31:0] t_wdata,
  input  logic        t_rd_valid,
  input  logic [4:0]  t_rd_reg,
  output logic        t_rd_done,
  output logic [31:0] t_rd_data,
  output logic        r_we,
  output logic [4:0]  r_wreg,
  output logic [31:0] r_wdata,
  output logic [4:0]  r_rregB,
  input  logic [31:0] r_rdataB,
  output logic [15:0] stall_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, FORCE, TREAD} state_t;
  state_t state;

  logic [36:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, fill, fill_nxt;
  logic [SW-1:0] starve;
  logic          empty, full, push, pop, proc_wr;
  logic [4:0]    head_reg;
  logic [31:0]   head_data;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fill     = wr_ptr - rd_ptr;
  assign fill_nxt = fill + (AW+1)'(push) - (AW+1)'(pop);
  assign t_wready = !full;
  assign push     = t_wvalid && !full;
  assign proc_wr  = p_we && (p_wreg != 5'd0);
  assign {head_reg, head_data} = mem[rd_ptr[AW-1:0]];
  assign r_rregB  = (state == TREAD) ? t_rd_reg : p_rregB;

  // Processor owns the write port in IDLE; otherwise the FIFO head drains.
  always_comb begin
    pop     = 1'b0;
    r_we    = 1'b0;
    r_wreg  = p_wreg;
    r_wdata = p_wdata;
    if (state == IDLE && proc_wr) begin
      r_we = 1'b1;
    end else if ((state == IDLE || state == FORCE) && !empty) begin
      pop     = 1'b1;
      r_we    = (head_reg != 5'd0);
      r_wreg  = head_reg;
      r_wdata = head_data;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {t_wreg, t_wdata};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      p_stall   <= 1'b0;
      t_rd_done <= 1'b0;
      t_rd_data <= 32'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      starve    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop || empty)                      starve <= '0;
      else if (starve != SW'(STARVE_LIMIT))  starve <= starve + 1'b1;
      t_rd_done <= (state == TREAD);
      if (state == TREAD) t_rd_data <= r_rdataB;
      // A pending read first flushes older test writes so it observes them.
      case (state)
        IDLE: begin
          if (starve == SW'(STARVE_LIMIT) || (t_rd_valid && !empty)) begin
            state   <= FORCE;
            p_stall <= 1'b1;
          end else if (t_rd_valid && !t_rd_done) begin
            state   <= TREAD;
            p_stall <= 1'b1;
          end
        end
        FORCE: begin
          if (fill_nxt == '0) begin
            state   <= IDLE;
            p_stall <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          p_stall <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                              stall_cnt <= 16'd0;
    else if (p_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
  assign stall_count = stall_cnt;
`else
  assign stall_count = 16'd0;
`endif

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
Shares the single write port and read port B of the regfile between the processor and the test host. Replaces the static test-mode mux so both can run concurrently. Test writes are buffered in a small FIFO and drained when the processor is not writing, with forced drains if they wait too long. Test reads steal read port B for one cycle by stalling the processor.

Parameters:
DEPTH, 4, test-write FIFO entries; power of 2, at least 2
STARVE_LIMIT, 8, cycles a non-empty FIFO may go without a pop before a forced drain

Ports:
clock  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
p_we  input  1  processor regfile write enable
p_wreg  input  5  processor write register
p_wdata  input  32  processor write data
p_rregB  input  5  processor read-port-B register
p_stall  output  1  registered; processor holds state while 1
t_wvalid  input  1  test write request
t_wready  output  1  FIFO can accept; equals !full
t_wreg  input  5  test write register
t_wdata  input  32  test write data
t_rd_valid  input  1  test read request (level; held until t_rd_done)
t_rd_reg  input  5  test read register
t_rd_done  output  1  one-cycle pulse; t_rd_data valid
t_rd_data  output  32  registered read result
r_we  output  1  to regfile write enable
r_wreg  output  5  to regfile write register
r_wdata  output  32  to regfile write data
r_rregB  output  5  to regfile read-port-B register
r_rdataB  input  32  from regfile port B (combinational read)
stall_count  output  16  see Optional Feature

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE, FIFO empty, starve counter 0.
  - p_stall=0, t_rd_done=0, t_rd_data=0, stall_count=0.
- FIFO push:
  - t_wvalid & t_wready pushes {t_wreg, t_wdata}.
  - When full, t_wready=0 even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH; full/empty are tracked with an extra pointer bit.
- FIFO pop and write-port steering (combinational from state and FIFO head):
  - IDLE, processor writing (p_we=1 and p_wreg!=0): r_we/r_wreg/r_wdata = processor values; no pop.
  - IDLE, processor not writing, FIFO non-empty: drive the FIFO head and pop (opportunistic drain).
  - FORCE: drive the FIFO head and pop every cycle; processor write ignored (processor re-presents it after the stall).
  - A head entry with wreg=0 pops with r_we=0.
  - Otherwise r_we=0.
- r_rregB = t_rd_reg in TREAD, else p_rregB.
- Starve counter:
  - Clears on any pop or when the FIFO is empty.
  - Otherwise increments, saturating at STARVE_LIMIT.
- States:
  - IDLE -> FORCE when counter==STARVE_LIMIT, or when t_rd_valid=1 and FIFO non-empty (reads see all earlier test writes).
  - IDLE -> TREAD when t_rd_valid=1, FIFO empty, and t_rd_done not asserted this cycle.
  - FORCE -> IDLE when the pop empties the FIFO. FORCE lasts exactly the entry count at entry plus any pushes accepted during FORCE.
  - TREAD -> IDLE after one cycle. At that edge t_rd_data <= r_rdataB; t_rd_done=1 in the following cycle.
  - Priority in IDLE: FORCE over TREAD.
- p_stall: registered, 1 in every cycle the state is FORCE or TREAD.
  - Latency from the triggering condition to stall is 1 cycle.
  - The processor write presented in the first forced cycle is lost; the processor must not commit it.
- Reset mid-operation: FIFO contents discarded; any pending read abandoned with no t_rd_done.

Optional Feature:
- ARB_STATS_EN defined: 16-bit saturating counter increments each cycle p_stall=1. Cleared only by reset; drives stall_count.
- ARB_STATS_EN undefined: stall_count tied to 0 and no counter flops.

Test Plan:
- Push (5, 0xAAAA0001) while p_we=0 -> r_we=1, r_wreg=5, r_wdata=0xAAAA0001 the next cycle; FIFO empty; p_stall stays 0.
- p_we=1 on p_wreg=3 continuously, push 2 entries -> after 8 non-pop cycles p_stall=1 for exactly 2 cycles; regs written in push order; then IDLE.
- Fill 4 entries with p_we=1 held -> t_wready=0; fifth t_wvalid not accepted until a pop; no entry lost or duplicated.
- FIFO empty, regfile r7=0x12345678, t_rd_valid with t_rd_reg=7 -> one stall cycle with r_rregB=7, then t_rd_done pulse with t_rd_data=0x12345678.
- Push (9, 0xBEEF), immediately t_rd_valid with t_rd_reg=9 while p_we=1 -> forced drain first, then read returns 0xBEEF.
- Assert reset low during FORCE with 3 entries -> p_stall=0 immediately; t_wready=1; no further r_we from FIFO; with ARB_STATS_EN, stall_count=0.
